// File: rtl/instr_sequencer_pkg.sv
// Shared types and constants for the instruction sequencer: FSM states,
// control-word layout of the 8-bit CPU datapath, and ALU operation codes.
package instr_sequencer_pkg;

    localparam int WORD_W = 10;

    // Control-word field positions: {we, selA[1:0], selB[1:0], aluOp[1:0], imm, selR[1:0]}
    localparam int CW_WE       = 9;
    localparam int CW_SELA_HI  = 8;
    localparam int CW_SELA_LO  = 7;
    localparam int CW_SELB_HI  = 6;
    localparam int CW_SELB_LO  = 5;
    localparam int CW_ALUOP_HI = 4;
    localparam int CW_ALUOP_LO = 3;
    localparam int CW_IMM      = 2;
    localparam int CW_SELR_HI  = 1;
    localparam int CW_SELR_LO  = 0;

    typedef enum logic [1:0] {
        ALU_ADD = 2'd0,
        ALU_SUB = 2'd1,
        ALU_MUL = 2'd2,
        ALU_AND = 2'd3
    } alu_op_e;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        FETCH     = 3'd1,
        ISSUE     = 3'd2,
        WAIT_STEP = 3'd3,
        DONE      = 3'd4
    } seq_state_e;

    // Assemble a control word from its fields.
    function automatic logic [WORD_W-1:0] make_cw(
        input logic       we,
        input logic [1:0] sel_a,
        input logic [1:0] sel_b,
        input alu_op_e    alu_op,
        input logic       imm,
        input logic [1:0] sel_r
    );
        return {we, sel_a, sel_b, alu_op, imm, sel_r};
    endfunction

endpackage

// File: rtl/instr_sequencer_if.sv
// Issue handshake between the sequencer and the datapath control-word input.
interface instr_sequencer_if;
    import instr_sequencer_pkg::*;

    logic              issue_valid;
    logic              issue_ready;
    logic [WORD_W-1:0] issue_word;

    modport master (output issue_valid, output issue_word, input issue_ready);
    modport slave  (input issue_valid, input issue_word, output issue_ready);

endinterface

// File: rtl/instr_sequencer_prog_ram.sv
// Program memory: one synchronous write port, one synchronous read port.
// The read register doubles as the issued control word, so it is the only
// part of the memory that is cleared by reset; the array keeps its contents.
module instr_sequencer_prog_ram
    import instr_sequencer_pkg::*;
#(
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we_i,
    input  logic [AW-1:0]     waddr_i,
    input  logic [WORD_W-1:0] wdata_i,
    input  logic              re_i,
    input  logic [AW-1:0]     raddr_i,
    output logic [WORD_W-1:0] rdata_o
);

    logic [WORD_W-1:0] mem_q [DEPTH];
    logic [WORD_W-1:0] rdata_q;

    // Array write; suppressed while reset is held so reset overrides a load.
    always_ff @(posedge clk) begin
        if (reset && we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Registered read; holds its value between fetches.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/instr_sequencer.sv
// Instruction sequencer: walks a loadable program memory and hands one
// control word per valid/ready handshake to the datapath, in free-run or
// single-step mode.
module instr_sequencer
    import instr_sequencer_pkg::*;
#(
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_en,
    input  logic [AW-1:0]     load_addr,
    input  logic [WORD_W-1:0] load_data,
    input  logic [AW:0]       prog_len,
    input  logic              start,
    input  logic              abort,
    input  logic              step_mode,
    input  logic              step,
    instr_sequencer_if.master iss,
    output logic [AW:0]       pc,
    output logic              busy,
    output logic              done,
    output logic              load_err
);

    localparam logic [AW:0] LEN_MAX = (AW+1)'(DEPTH);
    localparam logic [AW:0] PC_ONE  = (AW+1)'(1);

    seq_state_e        state_q, state_d;
    logic [AW:0]       pc_q, pc_d;
    logic [AW:0]       len_q, len_d;
    logic              load_err_q, load_err_d;
    logic [AW:0]       pc_inc;
    logic [AW:0]       len_clip;
    logic              ram_we;
    logic              ram_re;
    logic [WORD_W-1:0] ram_rdata;

    assign pc_inc   = pc_q + PC_ONE;
    assign len_clip = (prog_len > LEN_MAX) ? LEN_MAX : prog_len;

    instr_sequencer_prog_ram #(
        .DEPTH (DEPTH)
    ) u_prog_ram (
        .clk     (clk),
        .reset   (reset),
        .we_i    (ram_we),
        .waddr_i (load_addr),
        .wdata_i (load_data),
        .re_i    (ram_re),
        .raddr_i (pc_q[AW-1:0]),
        .rdata_o (ram_rdata)
    );

    // Next-state, program counter, length latch and memory strobes.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        len_d      = len_q;
        ram_we     = 1'b0;
        ram_re     = 1'b0;
        load_err_d = load_en && (state_q != IDLE);

        unique case (state_q)
            IDLE: begin
                // Write lands at this edge, ahead of the first fetch read.
                ram_we = load_en;
                if (start) begin
                    pc_d    = '0;
                    len_d   = len_clip;
                    state_d = (len_clip == '0) ? DONE : FETCH;
                end
            end
            FETCH: begin
                ram_re  = 1'b1;
                state_d = ISSUE;
            end
            ISSUE: begin
                if (iss.issue_ready) begin
                    pc_d = pc_inc;
                    if (pc_inc == len_q) begin
                        state_d = DONE;
                    end else if (step_mode) begin
                        state_d = WAIT_STEP;
                    end else begin
                        state_d = FETCH;
                    end
                end
            end
            WAIT_STEP: begin
                if (step) begin
                    state_d = FETCH;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Abort wins over an accepting handshake: the word is not counted.
        if (abort && (state_q != IDLE)) begin
            state_d = IDLE;
            pc_d    = pc_q;
            ram_re  = 1'b0;
        end
    end

    // Control state registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= IDLE;
            pc_q       <= '0;
            len_q      <= '0;
            load_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            len_q      <= len_d;
            load_err_q <= load_err_d;
        end
    end

    assign iss.issue_valid = (state_q == ISSUE);
    assign iss.issue_word  = ram_rdata;
    assign pc              = pc_q;
    assign busy            = (state_q != IDLE);
    assign done            = (state_q == DONE);
    assign load_err        = load_err_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed testbench for instr_sequencer.
module tb_instr_sequencer;
    import instr_sequencer_pkg::*;

    localparam int DEPTH = 16;
    localparam int AW    = $clog2(DEPTH);

    logic              clk = 1'b0;
    logic              reset;
    logic              load_en;
    logic [AW-1:0]     load_addr;
    logic [WORD_W-1:0] load_data;
    logic [AW:0]       prog_len;
    logic              start;
    logic              abort;
    logic              step_mode;
    logic              step;
    logic [AW:0]       pc;
    logic              busy;
    logic              done;
    logic              load_err;

    int n_tests = 0;
    int n_fail  = 0;
    int hs_cnt  = 0;
    int hs0;
    bit got;

    instr_sequencer_if iss ();

    instr_sequencer #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .load_en   (load_en),
        .load_addr (load_addr),
        .load_data (load_data),
        .prog_len  (prog_len),
        .start     (start),
        .abort     (abort),
        .step_mode (step_mode),
        .step      (step),
        .iss       (iss),
        .pc        (pc),
        .busy      (busy),
        .done      (done),
        .load_err  (load_err)
    );

    always #5 clk = ~clk;

    // Count completed handshakes (an abort or reset in the same cycle cancels it).
    always @(posedge clk) begin
        if (reset && !abort && iss.issue_valid && iss.issue_ready) begin
            hs_cnt <= hs_cnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic load_word(input logic [AW-1:0] a, input logic [WORD_W-1:0] d);
        load_en   = 1'b1;
        load_addr = a;
        load_data = d;
        tick();
        load_en   = 1'b0;
    endtask

    task automatic start_run(input logic [AW:0] len);
        prog_len = len;
        start    = 1'b1;
        tick();
        start    = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 200 && busy; i++) tick();
        chk(tag, busy, 0);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b0; load_en = 1'b0; load_addr = '0; load_data = '0;
        prog_len = '0; start = 1'b0; abort = 1'b0; step_mode = 1'b0; step = 1'b0;
        iss.issue_ready = 1'b0;
        tick(); tick();

        // Reset state
        chk("rst_valid", iss.issue_valid, 0);
        chk("rst_word", iss.issue_word, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_lerr", load_err, 0);
        chk("rst_pc", pc, 0);
        reset = 1'b1;
        tick();

        load_word(0, 10'h300);
        load_word(1, 10'h048);
        load_word(2, 10'h00D);

        // Free run, ready tied high
        iss.issue_ready = 1'b1;
        start_run(3);
        chk("fr_fetch_busy", busy, 1);
        chk("fr_fetch_valid", iss.issue_valid, 0);
        tick();
        chk("fr_w0_valid", iss.issue_valid, 1);
        chk("fr_w0_word", iss.issue_word, 10'h300);
        chk("fr_w0_pc", pc, 0);
        tick();
        chk("fr_gap_valid", iss.issue_valid, 0);
        chk("fr_gap_pc", pc, 1);
        tick();
        chk("fr_w1_word", iss.issue_word, 10'h048);
        chk("fr_w1_valid", iss.issue_valid, 1);
        tick(); tick();
        chk("fr_w2_word", iss.issue_word, 10'h00D);
        chk("fr_w2_pc", pc, 2);
        tick();
        chk("fr_done", done, 1);
        chk("fr_done_pc", pc, 3);
        chk("fr_done_valid", iss.issue_valid, 0);
        tick();
        chk("fr_after_done", done, 0);
        chk("fr_after_busy", busy, 0);
        chk("fr_after_pc", pc, 3);

        // Backpressure on word 1
        hs0 = hs_cnt;
        start_run(3);
        tick();
        chk("bp_w0_word", iss.issue_word, 10'h300);
        tick();
        iss.issue_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("bp_hold_valid", iss.issue_valid, 1);
            chk("bp_hold_word", iss.issue_word, 10'h048);
            chk("bp_hold_pc", pc, 1);
        end
        iss.issue_ready = 1'b1;
        tick();
        chk("bp_rel_valid", iss.issue_valid, 0);
        chk("bp_rel_pc", pc, 2);
        tick();
        chk("bp_w2_word", iss.issue_word, 10'h00D);
        tick();
        chk("bp_done", done, 1);
        wait_idle("bp_idle");
        chk("bp_hs_count", hs_cnt - hs0, 3);

        // Single-step mode
        step_mode = 1'b1;
        start_run(2);
        tick();
        chk("st_w0_word", iss.issue_word, 10'h300);
        step = 1'b1;
        tick();
        step = 1'b0;
        chk("st_wait_valid", iss.issue_valid, 0);
        chk("st_wait_busy", busy, 1);
        chk("st_wait_pc", pc, 1);
        tick();
        chk("st_ignored_valid", iss.issue_valid, 0);
        chk("st_ignored_busy", busy, 1);
        step = 1'b1;
        tick();
        step = 1'b0;
        chk("st_fetch_valid", iss.issue_valid, 0);
        tick();
        chk("st_w1_valid", iss.issue_valid, 1);
        chk("st_w1_word", iss.issue_word, 10'h048);
        tick();
        chk("st_done", done, 1);
        chk("st_done_pc", pc, 2);
        step_mode = 1'b0;
        wait_idle("st_idle");

        // Zero-length program
        hs0 = hs_cnt;
        start_run(0);
        chk("z_busy", busy, 1);
        chk("z_done", done, 1);
        chk("z_valid", iss.issue_valid, 0);
        tick();
        chk("z_busy_after", busy, 0);
        chk("z_done_after", done, 0);
        chk("z_hs", hs_cnt - hs0, 0);

        // Length clipped to DEPTH
        for (int a = 3; a < DEPTH; a++) load_word(AW'(a), WORD_W'(10'h100 + a));
        hs0 = hs_cnt;
        got = 1'b0;
        start_run(31);
        for (int i = 0; i < 200 && !got; i++) begin
            if (done) got = 1'b1;
            else tick();
        end
        chk("clip_done_seen", got, 1);
        chk("clip_pc", pc, 16);
        chk("clip_hs", hs_cnt - hs0, 16);
        chk("clip_last_word", iss.issue_word, 10'h10F);
        wait_idle("clip_idle");

        // Abort in ISSUE with ready high
        hs0 = hs_cnt;
        start_run(3);
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("ab_busy", busy, 0);
        chk("ab_valid", iss.issue_valid, 0);
        chk("ab_pc", pc, 0);
        chk("ab_done", done, 0);
        chk("ab_hs", hs_cnt - hs0, 0);
        tick();
        chk("ab_no_done", done, 0);

        // Load while busy is dropped and flagged
        start_run(3);
        load_word(1, 10'h3FF);
        chk("le_pulse", load_err, 1);
        tick();
        chk("le_pulse_end", load_err, 0);
        wait_idle("le_idle");
        start_run(2);
        tick(); tick(); tick();
        chk("le_mem_kept", iss.issue_word, 10'h048);
        wait_idle("le_idle2");

        // Reset in the middle of a run
        hs0 = hs_cnt;
        iss.issue_ready = 1'b0;
        start_run(3);
        tick();
        chk("mr_valid_pre", iss.issue_valid, 1);
        reset = 1'b0;
        tick();
        chk("mr_valid", iss.issue_valid, 0);
        chk("mr_word", iss.issue_word, 0);
        chk("mr_busy", busy, 0);
        chk("mr_pc", pc, 0);
        chk("mr_hs", hs_cnt - hs0, 0);
        reset = 1'b1;
        iss.issue_ready = 1'b1;
        tick();

        // Load and start in the same IDLE cycle
        load_en   = 1'b1;
        load_addr = '0;
        load_data = 10'h2A5;
        prog_len  = 1;
        start     = 1'b1;
        tick();
        load_en = 1'b0;
        start   = 1'b0;
        chk("ls_no_err", load_err, 0);
        tick();
        chk("ls_valid", iss.issue_valid, 1);
        chk("ls_word", iss.issue_word, 10'h2A5);
        tick();
        chk("ls_done", done, 1);
        chk("ls_pc", pc, 1);
        wait_idle("ls_idle");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
